// File: rtl/channel_cfg_scheduler_if.sv
// ---------------------------------------------------------------------------
// channel_cfg_scheduler_if
// Bundles the configuration write port, commit/abort controls, the PPS level
// and the active mux configuration outputs of channel_cfg_scheduler.
//   master : drives i_* (PPS, write request, commit, abort), observes o_*
//   slave  : the scheduler itself, consumes i_* and drives o_*
// ---------------------------------------------------------------------------
interface channel_cfg_scheduler_if #(
    parameter int N_CHANNELS = 4,
    parameter int CH_W       = 2
);
    logic                  i_pps;
    logic                  i_wr_valid;
    logic [CH_W-1:0]       i_wr_ch;
    logic                  i_wr_en;
    logic                  i_wr_sel;
    logic                  o_wr_ready;
    logic                  i_commit;
    logic                  i_abort;
    logic [N_CHANNELS-1:0] o_enable;
    logic [N_CHANNELS-1:0] o_selector;
    logic                  o_armed;
    logic                  o_commit_done;
    logic                  o_timeout;

    modport master (
        output i_pps, i_wr_valid, i_wr_ch, i_wr_en, i_wr_sel, i_commit, i_abort,
        input  o_wr_ready, o_enable, o_selector, o_armed, o_commit_done, o_timeout
    );

    modport slave (
        input  i_pps, i_wr_valid, i_wr_ch, i_wr_en, i_wr_sel, i_commit, i_abort,
        output o_wr_ready, o_enable, o_selector, o_armed, o_commit_done, o_timeout
    );
endinterface

// File: rtl/channel_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// channel_cfg_scheduler
// Stages per-channel enable/selector settings into shadow registers and
// applies all of them together on the next PPS rising edge after a commit,
// so the channel muxes never switch source mid-second. A watchdog moves to
// FAULT if no PPS edge arrives within TIMEOUT_CYCLES of arming.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : PPS level, write port (valid/ch/en/sel/ready),
//                  commit/abort, active enable/selector, armed,
//                  commit_done pulse, timeout flag
// ---------------------------------------------------------------------------
module channel_cfg_scheduler #(
    parameter int N_CHANNELS     = 4,
    parameter int CH_W           = 2,
    parameter int TIMEOUT_CYCLES = 120000000,
    parameter int TO_W           = 27
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    channel_cfg_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TERM_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [TO_W-1:0]       counter_q, counter_d;
    logic                  pps_d_q;
    logic [N_CHANNELS-1:0] shadow_en_q, shadow_en_d;
    logic [N_CHANNELS-1:0] shadow_sel_q, shadow_sel_d;
    logic [N_CHANNELS-1:0] active_en_q, active_en_d;
    logic [N_CHANNELS-1:0] active_sel_q, active_sel_d;
    logic                  done_q, done_d;

    logic                  wr_accept;
    logic                  pps_rise;
    logic [N_CHANNELS-1:0] wr_hit;

    assign wr_accept = bus.i_wr_valid && (state_q == ST_IDLE);
    assign pps_rise  = bus.i_pps & ~pps_d_q;

    // Channel indices at or beyond N_CHANNELS decode to no hit, so such
    // writes are accepted but silently dropped.
    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_wr_decode
            assign wr_hit[gi] = wr_accept && (bus.i_wr_ch == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        shadow_en_d  = shadow_en_q;
        shadow_sel_d = shadow_sel_q;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (wr_hit[i]) begin
                shadow_en_d[i]  = bus.i_wr_en;
                shadow_sel_d[i] = bus.i_wr_sel;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        active_en_d  = active_en_q;
        active_sel_d = active_sel_q;
        done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A PPS edge coinciding with the commit is deliberately not
                // used: edges are only examined once ARMED.
                if (bus.i_commit) begin
                    state_d   = ST_ARMED;
                    counter_d = '0;
                end
            end
            ST_ARMED: begin
                counter_d = counter_q + 1'b1;
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                end else if (pps_rise) begin
                    // Shadow cannot change while ARMED, so shadow_q is final.
                    active_en_d  = shadow_en_q;
                    active_sel_d = shadow_sel_q;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else if (counter_q == TERM_COUNT) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                end else if (bus.i_commit) begin
                    state_d   = ST_ARMED;
                    counter_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            pps_d_q      <= 1'b0;
            shadow_en_q  <= '0;
            shadow_sel_q <= '0;
            active_en_q  <= '0;
            active_sel_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            pps_d_q      <= bus.i_pps;
            shadow_en_q  <= shadow_en_d;
            shadow_sel_q <= shadow_sel_d;
            active_en_q  <= active_en_d;
            active_sel_q <= active_sel_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_wr_ready    = (state_q == ST_IDLE);
    assign bus.o_armed       = (state_q == ST_ARMED);
    assign bus.o_timeout     = (state_q == ST_FAULT);
    assign bus.o_commit_done = done_q;
    assign bus.o_enable      = active_en_q;
    assign bus.o_selector    = active_sel_q;
endmodule
